// File: rtl/scr1_bpu_pkg.sv
// Shared types and helpers for the SCR1 gshare branch predictor:
// 2-bit saturating counters and the BTB entry layout.
`ifndef SCR1_XLEN
`define SCR1_XLEN 32
`endif

package scr1_bpu_pkg;

    localparam int unsigned XLEN = `SCR1_XLEN;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

    // Tag is held zero-extended to XLEN so the type stays parameter-free.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] tag;
        logic [XLEN-1:0] target;
    } btb_entry_t;

    function automatic ctr_t ctr_inc(input ctr_t c);
        return (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'b01);
    endfunction

    function automatic ctr_t ctr_dec(input ctr_t c);
        return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'b01);
    endfunction

    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        return taken ? ctr_inc(c) : ctr_dec(c);
    endfunction

endpackage

// File: rtl/scr1_bpu_btb.sv
// Direct-mapped tagged branch target buffer: combinational read,
// synchronous write, valid bits cleared by the asynchronous reset.
module scr1_bpu_btb
    import scr1_bpu_pkg::*;
#(
    parameter int unsigned BTB_DEPTH = 256,
    parameter int unsigned TAG_W     = 12,
    parameter int unsigned PC_LSB    = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] rd_pc,
    output logic            rd_hit,
    output logic [XLEN-1:0] rd_target,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_pc,
    input  logic [XLEN-1:0] wr_target
);

    localparam int unsigned IDX_W   = $clog2(BTB_DEPTH);
    localparam int unsigned TAG_LSB = IDX_W + PC_LSB;

    logic [BTB_DEPTH-1:0] valid_r;
    logic [TAG_W-1:0]     tag_mem_r [BTB_DEPTH];
    logic [XLEN-1:0]      tgt_mem_r [BTB_DEPTH];

    logic [IDX_W-1:0]     rd_idx_s;
    logic [IDX_W-1:0]     wr_idx_s;
    logic [TAG_W-1:0]     rd_tag_s;
    logic [TAG_W-1:0]     wr_tag_s;
    btb_entry_t           rd_entry_s;
    logic [2*XLEN-1:0]    unused_pc_s;

    assign rd_idx_s = rd_pc[TAG_LSB-1:PC_LSB];
    assign rd_tag_s = rd_pc[TAG_LSB+TAG_W-1:TAG_LSB];
    assign wr_idx_s = wr_pc[TAG_LSB-1:PC_LSB];
    assign wr_tag_s = wr_pc[TAG_LSB+TAG_W-1:TAG_LSB];

    // Offset bits below PC_LSB and bits above the tag take no part in the lookup.
    assign unused_pc_s = {rd_pc, wr_pc};

    assign rd_entry_s.valid  = valid_r[rd_idx_s];
    assign rd_entry_s.tag    = XLEN'(tag_mem_r[rd_idx_s]);
    assign rd_entry_s.target = tgt_mem_r[rd_idx_s];

    assign rd_hit    = rd_entry_s.valid && (rd_entry_s.tag == XLEN'(rd_tag_s));
    assign rd_target = rd_entry_s.target;

    // Valid bits: cleared on reset, set on every taken-branch write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {BTB_DEPTH{1'b0}};
        end else if (wr_en) begin
            valid_r[wr_idx_s] <= 1'b1;
        end
    end

    // Tag/target payload is only meaningful behind a set valid bit, so it has no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem_r[wr_idx_s] <= wr_tag_s;
            tgt_mem_r[wr_idx_s] <= wr_target;
        end
    end

endmodule

// File: rtl/scr1_bpu_gshare.sv
// SCR1 gshare branch predictor: tagged BTB + PHT of 2-bit counters + speculative GHR.
// Define SCR1_BPU_GSHARE_EN for PC^GHR indexing; without it the PHT is bimodal (PC only).
module scr1_bpu_gshare
    import scr1_bpu_pkg::*;
#(
    parameter int unsigned PHT_DEPTH = 1024,
    parameter int unsigned BTB_DEPTH = 256,
    parameter int unsigned GHR_W     = 8,
    parameter int unsigned TAG_W     = 12,
    parameter int unsigned PC_LSB    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 lkp_vld_i,
    input  logic [`SCR1_XLEN-1:0] lkp_pc_i,
    output logic                 pred_vld_o,
    output logic                 pred_taken_o,
    output logic [`SCR1_XLEN-1:0] pred_target_o,
    output logic [GHR_W-1:0]     pred_meta_o,
    input  logic                 upd_vld_i,
    input  logic [`SCR1_XLEN-1:0] upd_pc_i,
    input  logic                 upd_taken_i,
    input  logic [`SCR1_XLEN-1:0] upd_target_i,
    input  logic [GHR_W-1:0]     upd_meta_i,
    input  logic                 upd_mispred_i
);

    localparam int unsigned PHT_IW = $clog2(PHT_DEPTH);

    ctr_t [PHT_DEPTH-1:0] pht_r;

    logic [PHT_IW-1:0] lkp_pc_idx_s;
    logic [PHT_IW-1:0] upd_pc_idx_s;
    logic [PHT_IW-1:0] lkp_idx_s;
    logic [PHT_IW-1:0] upd_idx_s;
    logic [GHR_W-1:0]  ghr_s;
    logic              repair_s;
    logic              lkp_acc_s;
    logic              lkp_taken_s;
    ctr_t              lkp_ctr_s;
    logic              btb_hit_s;
    logic [XLEN-1:0]   btb_target_s;

    assign lkp_pc_idx_s = lkp_pc_i[PHT_IW+PC_LSB-1:PC_LSB];
    assign upd_pc_idx_s = upd_pc_i[PHT_IW+PC_LSB-1:PC_LSB];

`ifdef SCR1_BPU_GSHARE_EN
    logic [GHR_W-1:0] ghr_r;

    assign ghr_s     = ghr_r;
    assign repair_s  = upd_vld_i & upd_mispred_i;
    assign lkp_idx_s = lkp_pc_idx_s ^ PHT_IW'(ghr_r);
    assign upd_idx_s = upd_pc_idx_s ^ PHT_IW'(upd_meta_i);

    // Speculative history: repair from the resolved branch beats a lookup shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_r <= {GHR_W{1'b0}};
        end else if (repair_s) begin
            ghr_r <= {upd_meta_i[GHR_W-2:0], upd_taken_i};
        end else if (lkp_vld_i && btb_hit_s) begin
            ghr_r <= {ghr_r[GHR_W-2:0], lkp_taken_s};
        end
    end
`else
    logic [GHR_W:0] unused_meta_s;

    assign unused_meta_s = {upd_meta_i, upd_mispred_i};
    assign ghr_s         = {GHR_W{1'b0}};
    assign repair_s      = 1'b0;
    assign lkp_idx_s     = lkp_pc_idx_s;
    assign upd_idx_s     = upd_pc_idx_s;
`endif

    assign lkp_acc_s   = lkp_vld_i & ~repair_s;
    assign lkp_ctr_s   = pht_r[lkp_idx_s];
    assign lkp_taken_s = btb_hit_s & lkp_ctr_s[1];

    scr1_bpu_btb #(
        .BTB_DEPTH (BTB_DEPTH),
        .TAG_W     (TAG_W),
        .PC_LSB    (PC_LSB)
    ) u_btb (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_pc     (lkp_pc_i),
        .rd_hit    (btb_hit_s),
        .rd_target (btb_target_s),
        .wr_en     (upd_vld_i & upd_taken_i),
        .wr_pc     (upd_pc_i),
        .wr_target (upd_target_i)
    );

    // Pattern history table: every resolved branch trains its counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pht_r <= {PHT_DEPTH{CTR_WNT}};
        end else if (upd_vld_i) begin
            pht_r[upd_idx_s] <= ctr_next(pht_r[upd_idx_s], upd_taken_i);
        end
    end

    // Prediction outputs: valid pulses for one cycle, payload holds until the next lookup.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_vld_o    <= 1'b0;
            pred_taken_o  <= 1'b0;
            pred_target_o <= {XLEN{1'b0}};
            pred_meta_o   <= {GHR_W{1'b0}};
        end else begin
            pred_vld_o <= lkp_acc_s;
            if (lkp_acc_s) begin
                pred_taken_o  <= lkp_taken_s;
                pred_target_o <= lkp_taken_s ? btb_target_s : {XLEN{1'b0}};
                pred_meta_o   <= ghr_s;
            end
        end
    end

endmodule

// File: doc/scr1_bpu_gshare.md
# scr1_bpu_gshare

Parametrised gshare branch predictor for the SCR1 fetch unit. It combines a direct-mapped, tagged branch target buffer (BTB) with a pattern history table (PHT) of 2-bit saturating counters, indexed by PC XOR global history. It keeps a speculative global history register (GHR) and repairs it on misprediction. It sits between the IFU fetch-address path and the EXU branch-resolution path.

## Interface
- PHT_DEPTH, 1024: PHT entries; must be a power of two.
- BTB_DEPTH, 256: BTB entries; must be a power of two.
- GHR_W, 8: global history bits; GHR_W <= log2(PHT_DEPTH).
- TAG_W, 12: BTB tag width; TAG_W + log2(BTB_DEPTH) + PC_LSB <= `SCR1_XLEN.
- PC_LSB, 1: lowest PC bit used for indexing (1 = RVC, 2 = RVI only).
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- lkp_vld_i  in  1  lookup request this cycle.
- lkp_pc_i  in  `SCR1_XLEN  fetch PC to predict.
- pred_vld_o  out  1  prediction result valid (registered).
- pred_taken_o  out  1  predicted taken.
- pred_target_o  out  `SCR1_XLEN  predicted target; 0 when not taken.
- pred_meta_o  out  GHR_W  GHR snapshot used by this lookup; returned with the update.
- upd_vld_i  in  1  resolved branch update.
- upd_pc_i  in  `SCR1_XLEN  PC of the resolved branch.
- upd_taken_i  in  1  actual direction.
- upd_target_i  in  `SCR1_XLEN  actual target.
- upd_meta_i  in  GHR_W  meta returned from the prediction.
- upd_mispred_i  in  1  direction or target mispredicted; qualified by upd_vld_i.

## Operation
- BTB index: pc[log2(BTB_DEPTH)+PC_LSB-1:PC_LSB]. Tag: the next TAG_W bits above the index. Each entry holds {valid, tag, target}.
- PHT index:
  - Build g by zero-extending the GHR to log2(PHT_DEPTH) bits.
  - Index = pc[log2(PHT_DEPTH)+PC_LSB-1:PC_LSB] XOR g.
- Lookup: arrays are read combinationally from lkp_pc_i and the current GHR.
  - hit = valid && tag match.
  - taken = hit && ctr[1].
- Counters:
  - Saturate at 2'b00 and 2'b11.
  - Taken increments; not-taken decrements.
  - Reset value is 2'b01 (weakly not-taken).
- Update (upd_vld_i=1):
  - PHT index is computed with upd_meta_i as the history; that counter is trained.
  - If taken: the BTB entry is written {1, tag, upd_target_i}, allocating or overwriting.
  - If not taken: the BTB is untouched.
- GHR speculative update: on an accepted lookup with a BTB hit, GHR <= {GHR[GHR_W-2:0], taken}. A BTB miss does not shift the GHR.
- GHR repair: upd_vld_i && upd_mispred_i gives GHR <= {upd_meta_i[GHR_W-2:0], upd_taken_i}.
- Simultaneous repair and lookup:
  - Repair wins on the GHR.
  - The lookup is dropped: pred_vld_o=0 next cycle.
- Simultaneous update and lookup to the same entry: the lookup sees the pre-update contents (read-before-write).
- BTB and PHT collisions alias silently; there is no tag on the PHT.

## Timing
- Lookup latency is 1 cycle. The lookup is presented in cycle N; the pred_* outputs are valid in cycle N+1.
- pred_vld_o is a one-cycle pulse. pred_taken_o, pred_target_o and pred_meta_o hold until the next accepted lookup.
- Update latency is 1 cycle: the write takes effect at the next edge, and a lookup in cycle N+1 sees it.
- Reset values:
  - pred_vld_o=0, pred_taken_o=0, pred_target_o=0, pred_meta_o=0.
  - GHR=0, all BTB valid bits=0, all counters=2'b01.
- Reset asserted mid-operation clears all state immediately. Any pending result is lost.

## Configuration
- SCR1_BPU_GSHARE_EN defined: PHT is indexed by PC XOR GHR as above.
- SCR1_BPU_GSHARE_EN undefined (bimodal):
  - PHT index is the PC bits only.
  - The GHR register is removed; pred_meta_o is tied to 0 and upd_meta_i is ignored.
  - Repair becomes a no-op.

## Structure
- Package scr1_bpu_pkg holds:
  - typedef of the 2-bit counter with localparams CTR_WNT=2'b01 and CTR_WT=2'b10;
  - the BTB entry struct {valid, tag, target};
  - saturating increment/decrement functions.
- Sub-module scr1_bpu_btb holds the BTB array with combinational read and synchronous write. The PHT and GHR stay in the top module.

## Test plan
- After reset, lookup at PC 0x100 -> next cycle pred_vld_o=1, pred_taken_o=0, pred_target_o=0, pred_meta_o=0.
- Two taken updates of PC 0x100, target 0x200, meta 0 -> counter reaches 2'b11; lookup at 0x100 gives taken=1, target=0x200, and GHR becomes 1.
- Four not-taken updates on the same entry -> counter saturates at 2'b00, lookup gives not-taken, and the BTB entry keeps target 0x200.
- Aliasing: lookup at 0x100 + BTB_DEPTH*2 (same index, different tag) -> BTB miss, not-taken, GHR unchanged.
- Lookup and a mispredict update with meta 8'h05, taken=0 in the same cycle -> GHR=8'h0A and pred_vld_o=0 next cycle.
- Counter saturation at 2'b11, plus a reset asserted between a lookup and its result -> pred_vld_o stays 0 and all state returns to reset values.
